// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: execute redirect, instruction-memory request/response and the
// decode-side valid/ready handshake. master = fetch stage, slave = its environment.
interface fetch_stage_if;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        xcpt_o;
   logic [3:0]  xcpt_code_o;
   logic [31:0] id_decode_o;

   modport master (
      input  redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
             imem_rsp_data_i, ready_i,
      output imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, instr_o,
             xcpt_o, xcpt_code_o, id_decode_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, imem_req_ready_i, imem_rsp_valid_i,
             imem_rsp_data_i, ready_i,
      input  imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, instr_o,
             xcpt_o, xcpt_code_o, id_decode_o
   );
endinterface

// File: rtl/fetch_stage.sv
// Single-issue in-order fetch stage: one outstanding imem request, redirect handling,
// misaligned-PC exception. Define FETCH_KANATA_EN to compile in the Kanata trace-id counter.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
   input logic           clk_i,
   input logic           rstn_i,
   fetch_stage_if.master bus
);

   localparam logic [31:0] NOP_INSTR                  = 32'h0000_0013;
   localparam logic [3:0]  XCPT_INSTR_ADDR_MISALIGNED = 4'd0;

   typedef enum logic [2:0] {S_REQ, S_WAIT, S_DROP, S_OUT, S_HALT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc_q;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_pc_out;
   logic [31:0] r_instr_out;
   logic        r_xcpt_out;
   logic [3:0]  r_code_out;
   logic        r_halt_pend;
   logic        w_misaligned;
   logic        w_load_rsp;
   logic        w_load_mis;
   logic        w_req;
   logic        w_vld;

   assign w_misaligned = (r_pc_q[1:0] != 2'b00);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc_q;
      w_load_rsp  = 1'b0;
      w_load_mis  = 1'b0;
      w_req       = 1'b0;
      w_vld       = 1'b0;
      case (r_state)
         S_REQ: begin
            if (bus.redirect_i) begin
               w_state_nxt = S_REQ;
            end else if (w_misaligned) begin
               w_load_mis  = 1'b1;
               w_state_nxt = S_OUT;
            end else begin
               w_req = 1'b1;
               if (bus.imem_req_ready_i) w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response racing a redirect is simply discarded; otherwise DROP eats it later
            if (bus.redirect_i) begin
               w_state_nxt = bus.imem_rsp_valid_i ? S_REQ : S_DROP;
            end else if (bus.imem_rsp_valid_i) begin
               w_load_rsp  = 1'b1;
               w_pc_nxt    = r_pc_q + 32'd4;
               w_state_nxt = S_OUT;
            end
         end
         S_DROP: begin
            if (bus.imem_rsp_valid_i) w_state_nxt = S_REQ;
         end
         S_OUT: begin
            w_vld = !bus.redirect_i;
            if (bus.redirect_i) begin
               w_state_nxt = S_REQ;
            end else if (bus.ready_i) begin
               w_state_nxt = r_halt_pend ? S_HALT : S_REQ;
            end
         end
         S_HALT: begin
            if (bus.redirect_i) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
      if (bus.redirect_i) w_pc_nxt = bus.redirect_pc_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= S_REQ;
         r_pc_q      <= RESET_PC;
         r_pc_out    <= '0;
         r_instr_out <= '0;
         r_xcpt_out  <= 1'b0;
         r_code_out  <= '0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc_q  <= w_pc_nxt;
         if (w_load_rsp) begin
            r_pc_out    <= r_pc_q;
            r_instr_out <= bus.imem_rsp_data_i;
            r_xcpt_out  <= 1'b0;
            r_code_out  <= '0;
            r_halt_pend <= 1'b0;
         end else if (w_load_mis) begin
            r_pc_out    <= r_pc_q;
            r_instr_out <= NOP_INSTR;
            r_xcpt_out  <= 1'b1;
            r_code_out  <= XCPT_INSTR_ADDR_MISALIGNED;
            r_halt_pend <= 1'b1;
         end
      end
   end

`ifdef FETCH_KANATA_EN
   logic [31:0] r_kid;
   logic        w_hs;

   assign w_hs = w_vld && bus.ready_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_kid <= '0;
      else if (w_hs) r_kid <= r_kid + 32'd1;
   end

   assign bus.id_decode_o = r_kid;
`else
   assign bus.id_decode_o = '0;
`endif

   // Reset gating keeps both valids low while rstn_i is held, not just after the edge
   assign bus.imem_req_valid_o = w_req && rstn_i;
   assign bus.imem_req_addr_o  = r_pc_q;
   assign bus.valid_o          = w_vld && rstn_i;
   assign bus.pc_o             = r_pc_out;
   assign bus.instr_o          = r_instr_out;
   assign bus.xcpt_o           = r_xcpt_out;
   assign bus.xcpt_code_o      = r_code_out;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by randomized decode
// backpressure, memory latency and redirects, checked against a program-order model.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC   = 32'h0000_1000;
   localparam logic [3:0]  MIS_CODE = 4'd0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        xcpt;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fetch_stage_if bus();

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   exp_t exp_q[$];

   // probes posted by the stimulus process, evaluated by the monitor
   bit          p_cr, p_er, p_cv, p_ev;
   logic [31:0] p_ea;
   bit          done;

   int mem_lat  = 1;
   bit mem_rand = 1'b0;
   bit busy     = 1'b0;

   int n_vec  = 0;
   int n_fail = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h0050_0093;
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   // Program-order expectation: from a new fetch target, consecutive words until the
   // next redirect; a misaligned target yields a single exception entry then silence.
   task automatic push_stream(input logic [31:0] t);
      exp_q.delete();
      if (t[1:0] != 2'b00) begin
         exp_q.push_back('{t, 32'h0000_0013, 1'b1});
      end else begin
         for (int i = 0; i < 256; i++) begin
            logic [31:0] a;
            a = t + 32'(4 * i);
            exp_q.push_back('{a, memf(a), 1'b0});
         end
      end
   endtask

   task automatic cyc(input bit cr, input bit er, input logic [31:0] ea,
                      input bit cv, input bit ev);
      p_cr = cr; p_er = er; p_ea = ea; p_cv = cv; p_ev = ev;
      @(posedge clk); #1;
   endtask

   task automatic redir(input logic [31:0] t);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = t;
      push_stream(t);
   endtask

   // instruction memory: one request at a time, response after mem_lat cycles
   initial begin
      bit          fire;
      logic [31:0] fa, maddr;
      int          rem, lat;
      rem = 0; maddr = '0;
      bus.imem_req_ready_i = 1'b1;
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      forever begin
         @(negedge clk);
         fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
         fa   = bus.imem_req_addr_o;
         @(posedge clk); #1;
         bus.imem_rsp_valid_i = 1'b0;
         if (!rstn) begin
            busy = 1'b0;
         end else if (busy) begin
            rem--;
            if (rem == 0) begin
               busy = 1'b0;
               bus.imem_rsp_valid_i = 1'b1;
               bus.imem_rsp_data_i  = memf(maddr);
            end
         end else if (fire) begin
            lat   = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            maddr = fa;
            if (lat == 1) begin
               bus.imem_rsp_valid_i = 1'b1;
               bus.imem_rsp_data_i  = memf(maddr);
            end else begin
               busy = 1'b1;
               rem  = lat - 1;
            end
         end
         bus.imem_req_ready_i = !busy && (mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   // monitor / scoreboard
   int          model_id = 0;
   int          hs_cnt   = 0;
   bit          hold     = 1'b0;
   logic [31:0] h_pc, h_instr, h_id;
   logic        h_xcpt;
   logic [3:0]  h_code;
   exp_t        m_e;

   always @(negedge clk) begin
      if (!rstn) begin
         chk("rst_valid", 32'(bus.valid_o), 32'd0);
         chk("rst_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
         chk("rst_pc_o", bus.pc_o, 32'd0);
         chk("rst_instr_o", bus.instr_o, 32'd0);
         chk("rst_xcpt", {27'd0, bus.xcpt_o, bus.xcpt_code_o}, 32'd0);
         chk("rst_id", bus.id_decode_o, 32'd0);
         model_id = 0;
         hold     = 1'b0;
      end else begin
         if (p_cr) begin
            chk("req_valid", 32'(bus.imem_req_valid_o), 32'(p_er));
            if (p_er) chk("req_addr", bus.imem_req_addr_o, p_ea);
         end
         if (p_cv) chk("valid", 32'(bus.valid_o), 32'(p_ev));
         if (bus.redirect_i) begin
            chk("redirect_gates_valid", 32'(bus.valid_o), 32'd0);
            chk("redirect_gates_req", 32'(bus.imem_req_valid_o), 32'd0);
         end
         if (busy) chk("one_outstanding", 32'(bus.imem_req_valid_o), 32'd0);
         if (hold && !bus.redirect_i) begin
            chk("hold_valid", 32'(bus.valid_o), 32'd1);
            chk("hold_pc", bus.pc_o, h_pc);
            chk("hold_instr", bus.instr_o, h_instr);
            chk("hold_xcpt", {27'd0, bus.xcpt_o, bus.xcpt_code_o}, {27'd0, h_xcpt, h_code});
            chk("hold_id", bus.id_decode_o, h_id);
         end
         if (bus.valid_o && bus.ready_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_output: actual pc %h presented, required no output",
                        bus.pc_o);
            end else begin
               m_e = exp_q.pop_front();
               chk("out_pc", bus.pc_o, m_e.pc);
               chk("out_instr", bus.instr_o, m_e.instr);
               chk("out_xcpt", 32'(bus.xcpt_o), 32'(m_e.xcpt));
               chk("out_code", 32'(bus.xcpt_code_o), m_e.xcpt ? 32'(MIS_CODE) : 32'd0);
`ifdef FETCH_KANATA_EN
               chk("out_id", bus.id_decode_o, 32'(model_id));
`else
               chk("out_id", bus.id_decode_o, 32'd0);
`endif
            end
            model_id++;
            hs_cnt++;
         end
         hold    = bus.valid_o && !bus.ready_i && !bus.redirect_i;
         h_pc    = bus.pc_o;
         h_instr = bus.instr_o;
         h_xcpt  = bus.xcpt_o;
         h_code  = bus.xcpt_code_o;
         h_id    = bus.id_decode_o;
      end
      if (done) begin
         chk("liveness_handshakes", 32'(hs_cnt >= 100), 32'd1);
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
         $finish;
      end
   end

   initial begin
      logic [31:0] t;
      rstn = 1'b1;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.ready_i       = 1'b1;
      p_cr = 0; p_er = 0; p_cv = 0; p_ev = 0; p_ea = '0; done = 0;
      push_stream(RST_PC);
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // basic fetch: REQ, WAIT, OUT
      cyc(1, 1, 32'h1000, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1);
      cyc(1, 1, 32'h1004, 1, 0);
      // decode backpressure for 5 cycles
      bus.ready_i = 1'b0;
      cyc(1, 0, 0, 1, 0);
      repeat (5) cyc(1, 0, 0, 1, 1);
      bus.ready_i = 1'b1;
      cyc(1, 0, 0, 1, 1);
      // redirect while WAIT, response two cycles later is dropped
      mem_lat = 3;
      cyc(1, 1, 32'h1008, 1, 0);
      redir(32'h2000);
      cyc(1, 0, 0, 1, 0);
      bus.redirect_i = 1'b0;
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 0);
      mem_lat = 1;
      cyc(1, 1, 32'h2000, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1);
      // misaligned target, then halt until redirect
      redir(32'h2002);
      cyc(1, 0, 0, 1, 0);
      bus.redirect_i = 1'b0;
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1);
      repeat (4) cyc(1, 0, 0, 1, 0);
      redir(32'h3000);
      cyc(1, 0, 0, 1, 0);
      bus.redirect_i = 1'b0;
      cyc(1, 1, 32'h3000, 1, 0);
      cyc(1, 0, 0, 1, 0);
      // redirect concurrent with ready in OUT
      redir(32'h4000);
      cyc(1, 0, 0, 1, 0);
      bus.redirect_i = 1'b0;
      cyc(1, 1, 32'h4000, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1);
      // PC wrap-around
      redir(32'hFFFF_FFFC);
      cyc(1, 0, 0, 1, 0);
      bus.redirect_i = 1'b0;
      cyc(1, 1, 32'hFFFF_FFFC, 1, 0);
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1);
      mem_lat = 3;
      cyc(1, 1, 32'h0000_0000, 1, 0);
      // reset asserted mid-WAIT
      rstn = 1'b0;
      push_stream(RST_PC);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      mem_lat = 1;
      rstn = 1'b1;
      cyc(1, 1, RST_PC, 1, 0);

      // randomized phase
      mem_rand = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         bus.ready_i = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 4) begin
            t = 32'h0001_0000 + 32'($urandom_range(0, 4095)) * 32'd16;
            if ($urandom_range(0, 5) == 0) t = t + 32'($urandom_range(1, 3));
            redir(t);
         end else begin
            bus.redirect_i = 1'b0;
         end
         cyc(0, 0, 0, 0, 0);
      end
      bus.redirect_i = 1'b0;
      done = 1'b1;
      repeat (4) @(posedge clk);
      $display("FAIL end_of_test: monitor did not finish");
      $fatal(1, "monitor did not finish");
   end

endmodule
